pipe_tag_tracker: RTL and testbench
===================================

// Module: pipe_tag_tracker
// PURPOSE
//  Producer side of the hazard/forwarding interface of the 5-stage pipelined CPU.
//  Each cycle it takes the ID-stage control word from the control unit and carries the
//  destination tags down the EXE, MEM and WB pipeline registers. The control unit reads
//  them back as ern/ewreg/em2reg and mrn/mwreg/mm2reg for stall and forwarding decisions.
//  Inserts a bubble whenever the control unit stalls (wpcir=0) and keeps event counters
//  (cycles, retired instructions, load-use stalls).
// PARAMETERS
//  CNT_W   32   width of each event counter
// PORTS
//  clock     in   1      rising-edge clock; single clock domain
//  reset     in   1      synchronous, active-high reset
//  wpcir     in   1      0 = control unit stalls PC/IR this cycle (load-use hazard)
//  dwreg     in   1      ID instruction writes the register file
//  dm2reg    in   1      ID instruction is a load (result comes from dmem)
//  dwmem     in   1      ID instruction writes dmem
//  djal      in   1      ID instruction is jal (destination forced to r31)
//  dregrt    in   1      1 = destination is rt, 0 = destination is rd
//  drt       in   5      ID rt field
//  drd       in   5      ID rd field
//  cnt_clr   in   1      synchronous clear of all three counters
//  ern       out  5      EXE destination register
//  ewreg     out  1      EXE writes the register file
//  em2reg    out  1      EXE is a load
//  ewmem     out  1      EXE writes dmem
//  mrn       out  5      MEM destination register
//  mwreg     out  1      MEM writes the register file
//  mm2reg    out  1      MEM is a load
//  mwmem     out  1      MEM writes dmem
//  wrn       out  5      WB destination register
//  wwreg     out  1      WB writes the register file
//  wm2reg    out  1      WB is a load
//  cyc_cnt   out  CNT_W  cycles since reset/clear
//  ret_cnt   out  CNT_W  instructions leaving WB (valid, non-bubble)
//  stall_cnt out  CNT_W  cycles with wpcir=0
// BEHAVIOUR
//  - Destination select (combinational, ID): drn = djal ? 5'd31 : (dregrt ? drt : drd).
//  - Each stage holds {valid, rn, wreg, m2reg, wmem}. All are updated every rising edge.
//    There is no stall of EXE/MEM/WB.
//  - ID->EXE: if wpcir=1, EXE <= {1, drn, dwreg, dm2reg, dwmem}.
//    If wpcir=0, EXE <= bubble {0, 5'd0, 0, 0, 0}. A bubble is inserted whatever the d* inputs are.
//  - EXE->MEM and MEM->WB: plain copy of the full stage word, including the valid bit.
//  - rn=0 with wreg=1 is passed through unchanged; the consumer qualifies on rn!=0.
//  - Latency: an ID word is visible on e* one cycle later, on m* two cycles later,
//    and on w* three cycles later.
//  - Counters:
//    cyc_cnt += 1 every cycle.
//    stall_cnt += 1 when wpcir=0.
//    ret_cnt += 1 when the WB stage valid bit is 1 at the edge.
//    Counters wrap modulo 2^CNT_W with no saturation.
//  - cnt_clr=1 zeroes all three counters on that edge. Clear wins over a simultaneous increment.
//    Pipeline registers are not affected by cnt_clr.
//  - Reset (synchronous, active-high, highest priority): all stage words become bubbles,
//    all outputs are 0 and all counters are 0 after the edge. Reset mid-stream discards
//    in-flight instructions. In the first cycle after reset deasserts, all e*/m*/w* outputs are 0.
//  - No combinational path from any input to any output.
// TESTING
//  1. reset 1 cycle, then idle with wpcir=1 and all d*=0 -> all e*/m*/w* = 0;
//     cyc_cnt counts 1,2,3..., stall_cnt = 0.
//  2. lw r5 (dregrt=1, drt=5, dwreg=1, dm2reg=1) -> cycle+1 ern=5, ewreg=1, em2reg=1;
//     cycle+2 mrn=5, mm2reg=1; cycle+3 wrn=5, wm2reg=1; ret_cnt increments at cycle+4.
//  3. jal with drd=7, dregrt=0 -> ern=31, ewreg=1.
//     Then add with drd=9, dregrt=0 -> ern=9 (rd path).
//  4. load-use: hold wpcir=0 for 1 cycle while the d* inputs still show a valid add ->
//     ern=0, ewreg=0 next cycle; stall_cnt=1; the bubble does not increment ret_cnt 3 cycles later.
//  5. assert reset while 3 instructions are in flight -> next cycle all stage outputs = 0
//     and counters = 0; no ret_cnt increment.
//  6. CNT_W=4: run 16 cycles -> cyc_cnt wraps to 0.
//     cnt_clr together with wpcir=0 -> stall_cnt = 0 (clear wins).

Source files
------------

// File: rtl/pipe_tag_tracker.sv
// pipe_tag_tracker: carries ID-stage destination tags down the EXE/MEM/WB
// pipeline registers for the hazard/forwarding logic, inserts a bubble on a
// control-unit stall and keeps cycle/retire/stall event counters.
module pipe_tag_tracker #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wpcir,
    input  logic             dwreg,
    input  logic             dm2reg,
    input  logic             dwmem,
    input  logic             djal,
    input  logic             dregrt,
    input  logic [4:0]       drt,
    input  logic [4:0]       drd,
    input  logic             cnt_clr,
    output logic [4:0]       ern,
    output logic             ewreg,
    output logic             em2reg,
    output logic             ewmem,
    output logic [4:0]       mrn,
    output logic             mwreg,
    output logic             mm2reg,
    output logic             mwmem,
    output logic [4:0]       wrn,
    output logic             wwreg,
    output logic             wm2reg,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    // Stage word carried through EXE and MEM.
    typedef struct packed {
        logic       valid;
        logic [4:0] rn;
        logic       wreg;
        logic       m2reg;
        logic       wmem;
    } stage_t;

    // WB no longer needs the store flag: the dmem write has completed in MEM.
    typedef struct packed {
        logic       valid;
        logic [4:0] rn;
        logic       wreg;
        logic       m2reg;
    } wb_stage_t;

    localparam stage_t    BUBBLE    = '{valid: 1'b0, rn: 5'd0, wreg: 1'b0, m2reg: 1'b0, wmem: 1'b0};
    localparam wb_stage_t WB_BUBBLE = '{valid: 1'b0, rn: 5'd0, wreg: 1'b0, m2reg: 1'b0};
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [4:0] drn_s;
    stage_t     e_r;
    stage_t     m_r;
    wb_stage_t  w_r;
    logic [CNT_W-1:0] cyc_cnt_r;
    logic [CNT_W-1:0] ret_cnt_r;
    logic [CNT_W-1:0] stall_cnt_r;

    // Destination register select for the ID instruction (jal forces r31).
    always_comb begin
        drn_s = drd;
        if (djal) begin
            drn_s = 5'd31;
        end else if (dregrt) begin
            drn_s = drt;
        end else begin
            drn_s = drd;
        end
    end

    // Pipeline registers: ID->EXE with bubble on stall, then plain shift to MEM and WB.
    always_ff @(posedge clock) begin
        if (reset) begin
            e_r <= BUBBLE;
            m_r <= BUBBLE;
            w_r <= WB_BUBBLE;
        end else begin
            if (wpcir) begin
                e_r <= '{valid: 1'b1, rn: drn_s, wreg: dwreg, m2reg: dm2reg, wmem: dwmem};
            end else begin
                e_r <= BUBBLE;
            end
            m_r <= e_r;
            w_r <= '{valid: m_r.valid, rn: m_r.rn, wreg: m_r.wreg, m2reg: m_r.m2reg};
        end
    end

    // Event counters: reset, then clear, take priority over increments; wrap freely.
    always_ff @(posedge clock) begin
        if (reset) begin
            cyc_cnt_r   <= CNT_ZERO;
            ret_cnt_r   <= CNT_ZERO;
            stall_cnt_r <= CNT_ZERO;
        end else if (cnt_clr) begin
            cyc_cnt_r   <= CNT_ZERO;
            ret_cnt_r   <= CNT_ZERO;
            stall_cnt_r <= CNT_ZERO;
        end else begin
            cyc_cnt_r <= cyc_cnt_r + CNT_ONE;
            if (w_r.valid) begin
                ret_cnt_r <= ret_cnt_r + CNT_ONE;
            end else begin
                ret_cnt_r <= ret_cnt_r;
            end
            if (!wpcir) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign ern       = e_r.rn;
    assign ewreg     = e_r.wreg;
    assign em2reg    = e_r.m2reg;
    assign ewmem     = e_r.wmem;
    assign mrn       = m_r.rn;
    assign mwreg     = m_r.wreg;
    assign mm2reg    = m_r.m2reg;
    assign mwmem     = m_r.wmem;
    assign wrn       = w_r.rn;
    assign wwreg     = w_r.wreg;
    assign wm2reg    = w_r.m2reg;
    assign cyc_cnt   = cyc_cnt_r;
    assign ret_cnt   = ret_cnt_r;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_tag_tracker.sv
// Testbench for pipe_tag_tracker: directed scenarios followed by random
// traffic; a reference model pushes expected outputs into a scoreboard queue
// and an independent monitor pops and compares after every clock edge.
module tb_pipe_tag_tracker;

    localparam int CNT_W = 4;
    localparam int CNT_MOD = 16;

    logic clock = 1'b0;
    logic reset, wpcir, dwreg, dm2reg, dwmem, djal, dregrt, cnt_clr;
    logic [4:0] drt, drd;
    logic [4:0] ern, mrn, wrn;
    logic ewreg, em2reg, ewmem, mwreg, mm2reg, mwmem, wwreg, wm2reg;
    logic [CNT_W-1:0] cyc_cnt, ret_cnt, stall_cnt;

    pipe_tag_tracker #(.CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .wpcir(wpcir), .dwreg(dwreg),
        .dm2reg(dm2reg), .dwmem(dwmem), .djal(djal), .dregrt(dregrt),
        .drt(drt), .drd(drd), .cnt_clr(cnt_clr),
        .ern(ern), .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
        .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
        .wrn(wrn), .wwreg(wwreg), .wm2reg(wm2reg),
        .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    // An instruction as it occupies a pipeline slot.
    typedef struct {
        bit       v;
        bit [4:0] rn;
        bit       wreg;
        bit       m2reg;
        bit       wmem;
    } slot_t;

    // Full set of expected outputs after one clock edge.
    typedef struct {
        slot_t e, m, w;
        int    cyc, ret, stl;
    } exp_t;

    exp_t  exp_q[$];
    slot_t hist[$];   // hist[0] = in EXE, hist[1] = in MEM, hist[2] = in WB
    int    m_cyc, m_ret, m_stl;
    int    checks = 0;
    int    errors = 0;

    function automatic slot_t bubble();
        slot_t s;
        s.v = 1'b0; s.rn = 5'd0; s.wreg = 1'b0; s.m2reg = 1'b0; s.wmem = 1'b0;
        return s;
    endfunction

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the reference model, queue the expectation.
    task automatic step(input bit rst, input bit wp, input bit wreg, input bit m2r,
                        input bit wmem, input bit jal, input bit rgt,
                        input bit [4:0] rt, input bit [4:0] rd, input bit clr);
        slot_t nw, old_w;
        exp_t  x;
        reset = rst; wpcir = wp; dwreg = wreg; dm2reg = m2r; dwmem = wmem;
        djal = jal; dregrt = rgt; drt = rt; drd = rd; cnt_clr = clr;
        if (rst) begin
            hist = {bubble(), bubble(), bubble()};
            m_cyc = 0; m_ret = 0; m_stl = 0;
        end else begin
            old_w = hist[2];
            if (wp) begin
                nw.v = 1'b1;
                nw.rn = jal ? 5'd31 : (rgt ? rt : rd);
                nw.wreg = wreg; nw.m2reg = m2r; nw.wmem = wmem;
            end else begin
                nw = bubble();
            end
            hist.push_front(nw);
            void'(hist.pop_back());
            if (clr) begin
                m_cyc = 0; m_ret = 0; m_stl = 0;
            end else begin
                m_cyc = (m_cyc + 1) % CNT_MOD;
                if (!wp) m_stl = (m_stl + 1) % CNT_MOD;
                if (old_w.v) m_ret = (m_ret + 1) % CNT_MOD;
            end
        end
        x.e = hist[0]; x.m = hist[1]; x.w = hist[2];
        x.cyc = m_cyc; x.ret = m_ret; x.stl = m_stl;
        exp_q.push_back(x);
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
    endtask

    // Monitor: after each edge compare the DUT against the oldest expectation.
    always @(posedge clock) begin
        exp_t x;
        #2;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            check("ern",       int'(ern),       int'(x.e.rn));
            check("ewreg",     int'(ewreg),     int'(x.e.wreg));
            check("em2reg",    int'(em2reg),    int'(x.e.m2reg));
            check("ewmem",     int'(ewmem),     int'(x.e.wmem));
            check("mrn",       int'(mrn),       int'(x.m.rn));
            check("mwreg",     int'(mwreg),     int'(x.m.wreg));
            check("mm2reg",    int'(mm2reg),    int'(x.m.m2reg));
            check("mwmem",     int'(mwmem),     int'(x.m.wmem));
            check("wrn",       int'(wrn),       int'(x.w.rn));
            check("wwreg",     int'(wwreg),     int'(x.w.wreg));
            check("wm2reg",    int'(wm2reg),    int'(x.w.m2reg));
            check("cyc_cnt",   int'(cyc_cnt),   x.cyc);
            check("ret_cnt",   int'(ret_cnt),   x.ret);
            check("stall_cnt", int'(stall_cnt), x.stl);
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        hist = {bubble(), bubble(), bubble()};
        m_cyc = 0; m_ret = 0; m_stl = 0;
        // Reset, then idle.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        idle(3);
        // lw r5 flowing to WB and retiring.
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd0, 1'b0);
        idle(4);
        // jal (rd ignored) then add through the rd path.
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 5'd7, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 5'd9, 1'b0);
        // Load-use stall while ID shows a valid add, then the add issues.
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4, 5'd12, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4, 5'd12, 1'b0);
        idle(4);
        // Three instructions in flight (incl. rn=0 with wreg=1), then reset.
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd2, 5'd0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 5'd0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 5'd0, 1'b0);
        idle(3);
        // Counter wrap, then clear together with a stall.
        idle(17);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd6, 5'd8, 1'b1);
        idle(2);
        // Random traffic with occasional stalls, clears and resets.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                 1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 7) == 0, 1'($urandom),
                 5'($urandom), 5'($urandom), $urandom_range(0, 24) == 0);
        end
        idle(1);
        repeat (3) @(posedge clock);
        #3;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
